// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Instruction layout: [17:15] op, [14:10] rd, [9:5] rs2, [4:0] rs1.
package alu_seq_pkg;

    localparam int INSTR_W = 18;
    localparam int OP_W    = 3;
    localparam int REG_W   = 5;
    localparam int OP_LSB  = 15;
    localparam int RD_LSB  = 10;
    localparam int RS2_LSB = 5;
    localparam int RS1_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_GTU = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction field extraction and illegal-opcode detection.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [OP_W-1:0]    op,
    output logic [ADDR_W-1:0]  rd,
    output logic [ADDR_W-1:0]  rs2,
    output logic [ADDR_W-1:0]  rs1,
    output logic               illegal
);

    assign op      = instr[OP_LSB +: OP_W];
    assign rd      = ADDR_W'(instr[RD_LSB  +: REG_W]);
    assign rs2     = ADDR_W'(instr[RS2_LSB +: REG_W]);
    assign rs1     = ADDR_W'(instr[RS1_LSB +: REG_W]);
    assign illegal = !op_is_legal(op);

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state sequencer: read operands, drive external ALU, write back one result.
// Optional build macro ALU_SEQ_R0_PROTECT_EN suppresses register-file writes to r0.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  rf_raddr1,
    output logic [ADDR_W-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               rf_we,
    output logic [ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               err,
    output logic [CNT_W-1:0]   retired_cnt
);

    state_t              state_reg, state_next;
    logic [INSTR_W-1:0]  instr_reg;
    logic [DATA_W-1:0]   opa_reg, opb_reg, alu_res_reg, result_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [OP_W-1:0]     dec_op;
    logic [ADDR_W-1:0]   dec_rd, dec_rs2, dec_rs1;
    logic                dec_illegal;
    logic                accept;
    logic                wr_allow;

    alu_seq_decode #(.ADDR_W(ADDR_W)) u_decode (
        .instr   (instr_reg),
        .op      (dec_op),
        .rd      (dec_rd),
        .rs2     (dec_rs2),
        .rs1     (dec_rs1),
        .illegal (dec_illegal)
    );

`ifdef ALU_SEQ_R0_PROTECT_EN
    assign wr_allow = (dec_rd != '0);
`else
    assign wr_allow = 1'b1;
`endif

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Result and counter commit on the edge entering WB so they are visible alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg   <= '0;
            opa_reg     <= '0;
            opb_reg     <= '0;
            alu_res_reg <= '0;
            result_reg  <= '0;
            cnt_reg     <= '0;
        end else begin
            if (accept) begin
                instr_reg <= instr;
            end
            if (state_reg == READ) begin
                opa_reg <= rf_rdata1;
                opb_reg <= rf_rdata2;
            end
            if (state_reg == EXEC) begin
                alu_res_reg <= alu_result;
                if (!dec_illegal) begin
                    result_reg <= alu_result;
                    if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Ready is masked by rst_n so nothing is offered while reset is held.
    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        rf_we       = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready = rst_n;
                if (instr_valid && rst_n) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                busy       = 1'b1;
                state_next = WB;
            end
            WB: begin
                busy       = 1'b1;
                done       = 1'b1;
                err        = dec_illegal;
                rf_we      = !dec_illegal && wr_allow;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rf_raddr1   = dec_rs1;
    assign rf_raddr2   = dec_rs2;
    assign alu_a       = opa_reg;
    assign alu_b       = opb_reg;
    assign alu_sel     = dec_op;
    assign rf_waddr    = dec_rd;
    assign rf_wdata    = alu_res_reg;
    assign result      = result_reg;
    assign retired_cnt = cnt_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: register-file and ALU models around the sequencer, scoreboard of write-back results.
module tb_alu_op_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [17:0]       instr = '0;
    logic [ADDR_W-1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2, alu_a, alu_b, alu_result, rf_wdata, result;
    logic [2:0]        alu_sel;
    logic              rf_we, busy, done, err;
    logic [CNT_W-1:0]  retired_cnt;

    typedef struct {
        logic              we;
        logic              er;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] res;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t              sb[$];
    exp_t              e_mon;
    int                total = 0;
    int                bad = 0;
    logic [DATA_W-1:0] m_result = '0;
    logic [CNT_W-1:0]  m_cnt = '0;
    logic [DATA_W-1:0] rf_mem [32];

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .err         (err),
        .retired_cnt (retired_cnt)
    );

    function automatic logic [DATA_W-1:0] alu_model(input logic [2:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return (a > b) ? 32'd1 : 32'd0;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] init_val(input int i);
        case (i)
            13:      return 32'd5;
            10:      return 32'd3;
            12:      return 32'd3;
            9:       return 32'd5;
            default: return 32'(i) + 32'h100;
        endcase
    endfunction

    assign rf_rdata1  = rf_mem[rf_raddr1];
    assign rf_rdata2  = rf_mem[rf_raddr2];
    assign alu_result = alu_model(alu_sel, alu_a, alu_b);

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        logic legal;
        logic [DATA_W-1:0] r;
        legal = (op <= 3'd5);
        r = alu_model(op, rf_mem[rs1], rf_mem[rs2]);
        if (legal) begin
            m_result = r;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        e.we = legal;
`ifdef ALU_SEQ_R0_PROTECT_EN
        if (rd == 5'd0) e.we = 1'b0;
`endif
        e.er    = !legal;
        e.waddr = rd;
        e.wdata = r;
        e.res   = m_result;
        e.cnt   = m_cnt;
        sb.push_back(e);
        $display("issue op=%0d rd=%0d rs1=%0d rs2=%0d expect wdata=%0h we=%0b err=%0b cnt=%0d",
                 op, rd, rs1, rs2, r, e.we, e.er, m_cnt);
    endtask

    // Write-back monitor: every done pulse pops one expectation; writes/errors outside WB are faults.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'(1'b1));
                if (sb.size() != 0) begin
                    e_mon = sb.pop_front();
                    chk("wb_we", 64'(rf_we), 64'(e_mon.we));
                    chk("wb_err", 64'(err), 64'(e_mon.er));
                    chk("wb_result", 64'(result), 64'(e_mon.res));
                    chk("wb_cnt", 64'(retired_cnt), 64'(e_mon.cnt));
                    if (e_mon.we) begin
                        chk("wb_waddr", 64'(rf_waddr), 64'(e_mon.waddr));
                        chk("wb_wdata", 64'(rf_wdata), 64'(e_mon.wdata));
                    end
                    $display("retire waddr=%0d wdata=%0h we=%0b err=%0b result=%0h cnt=%0d",
                             rf_waddr, rf_wdata, rf_we, err, result, retired_cnt);
                end
            end else begin
                chk("we_outside_wb", 64'(rf_we), 64'(1'b0));
                chk("err_outside_wb", 64'(err), 64'(1'b0));
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs2, input logic [4:0] rs1);
        int n;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {op, rd, rs2, rs1};
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(n < 20), 64'(1'b1));
        push(op, rd, rs1, rs2);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("read_busy", 64'(busy), 64'(1'b1));
        chk("read_ready", 64'(instr_ready), 64'(1'b0));
        chk("read_raddr1", 64'(rf_raddr1), 64'(rs1));
        chk("read_raddr2", 64'(rf_raddr2), 64'(rs2));
        @(negedge clk);
        chk("exec_sel", 64'(alu_sel), 64'(op));
        chk("exec_done", 64'(done), 64'(1'b0));
        @(negedge clk);
        chk("wb_done_n3", 64'(done), 64'(1'b1));
        @(negedge clk);
        chk("idle_ready_n4", 64'(instr_ready), 64'(1'b1));
        chk("idle_busy", 64'(busy), 64'(1'b0));
    endtask

    initial begin
        int t[3];
        int acc;
        int cyc;

        #12;
        chk("rst_ready", 64'(instr_ready), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_we", 64'(rf_we), 64'(1'b0));
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cnt", 64'(retired_cnt), 64'd0);
        chk("rst_raddr1", 64'(rf_raddr1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(instr_ready), 64'(1'b1));

        send(3'd0, 5'd8, 5'd10, 5'd13);
        chk("r8_sum", 64'(rf_mem[8]), 64'd8);
        send(3'd1, 5'd7, 5'd9, 5'd12);
        send(3'd2, 5'd6, 5'd9, 5'd12);
        send(3'd2, 5'd5, 5'd12, 5'd9);
        send(3'd3, 5'd4, 5'd10, 5'd13);
        send(3'd5, 5'd3, 5'd10, 5'd13);
        send(3'd6, 5'd8, 5'd10, 5'd13);
        send(3'd7, 5'd8, 5'd10, 5'd13);
        chk("r8_kept", 64'(rf_mem[8]), 64'd8);
        send(3'd0, 5'd13, 5'd13, 5'd13);
        chk("r13_self", 64'(rf_mem[13]), 64'd10);

        // Continuous valid: accepts must be exactly 4 cycles apart.
        @(negedge clk);
        instr_valid = 1'b1;
        instr = {3'd0, 5'd20, 5'd10, 5'd12};
        acc = 0;
        cyc = 0;
        while (acc < 3 && cyc < 30) begin
            if (instr_ready) begin
                push(3'd0, 5'd20, 5'd12, 5'd10);
                t[acc] = cyc;
                acc++;
            end
            if (acc < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        chk("b2b_count", 64'(acc), 64'd3);
        chk("b2b_gap1", 64'(t[1] - t[0]), 64'd4);
        chk("b2b_gap2", 64'(t[2] - t[1]), 64'd4);
        repeat (5) @(negedge clk);

        // Reset during EXEC drops the in-flight instruction.
        instr_valid = 1'b1;
        instr = {3'd0, 5'd21, 5'd10, 5'd13};
        chk("pre_rst_ready", 64'(instr_ready), 64'(1'b1));
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("exec_busy", 64'(busy), 64'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(1'b0));
        chk("mid_rst_ready", 64'(instr_ready), 64'(1'b0));
        chk("mid_rst_we", 64'(rf_we), 64'(1'b0));
        chk("mid_rst_done", 64'(done), 64'(1'b0));
        chk("mid_rst_cnt", 64'(retired_cnt), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        m_cnt = '0;
        m_result = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 64'(instr_ready), 64'(1'b1));
        chk("r21_unwritten", 64'(rf_mem[21]), 64'(init_val(21)));

        send(3'd0, 5'd8, 5'd10, 5'd13);
        chk("post_rst_cnt", 64'(retired_cnt), 64'd1);

        send(3'd4, 5'd0, 5'd10, 5'd13);
`ifdef ALU_SEQ_R0_PROTECT_EN
        chk("r0_protected", 64'(rf_mem[0]), 64'(init_val(0)));
`else
        chk("r0_written", 64'(rf_mem[0]), 64'd7);
`endif
        chk("final_result", 64'(result), 64'd7);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
